// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer (8E1 when UART_TX_PARITY_EN is defined).
// Latency: a write into an idle, empty block drives the start bit two edges later.
// Backpressure: tx_full flags a full FIFO; writes while full are dropped and latch tx_overflow.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       uart_tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              wr_acc, pop;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              line_d, bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign tx_full  = (count == FULL_CNT);
  assign tx_empty = (count == '0);
  assign tx_busy  = (state_q != IDLE);
  assign wr_acc   = tx_wr && !tx_full;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + (ADDR_W + 1)'(wr_acc) - (ADDR_W + 1)'(pop);
      if (tx_wr && tx_full) tx_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    line_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (baud_q == BAUD_LAST);
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BW'(1);

    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Last stop cycle chains straight into the next start bit when data waits.
        if (bit_end) begin
          if (!tx_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_TX_PARITY_EN
    if (pop) par_d = ^mem[rd_ptr];
`endif

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      uart_tx <= line_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level model compared every cycle, plus directed literal checks.
module tb_uart_tx_fifo;
  localparam int C     = 16;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;

  logic       clk, rst, tx_wr;
  logic [7:0] tx_data;
  logic       tx_full, tx_empty, tx_busy, tx_overflow, uart_tx;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .tx_overflow(tx_overflow), .uart_tx(uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model: byte queue plus the current frame and a position within it.
  int         mq[$];
  bit         m_ok = 0, m_act, m_ovf;
  int         m_t, m_pre;
  bit         m_pop;
  logic [7:0] m_b;
  logic [10:0] m_frame;

  function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_act = 0; m_t = 0; m_ovf = 0; m_ok = 1;
    end else if (m_ok) begin
      m_pre = mq.size();
      m_pop = (m_pre > 0) && (!m_act || m_t == FL - 1);
      if (m_pop) m_b = 8'(mq.pop_front());
      if (tx_wr) begin
        if (m_pre < DEPTH) mq.push_back(int'(tx_data));
        else m_ovf = 1;
      end
      if (m_act) begin
        m_t++;
        if (m_t == FL) m_act = 0;
      end
      if (m_pop) begin
        m_act = 1; m_t = 0; m_frame = make_frame(m_b);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok)
      chk("model", {27'd0, uart_tx, tx_busy, tx_empty, tx_full, tx_overflow},
          {27'd0, (m_act ? m_frame[m_t / C] : 1'b1), m_act, mq.size() == 0,
           mq.size() == DEPTH, m_ovf});
  end

  // Line monitor: decodes frames by mid-bit sampling.
  int   rx_q[$], rx_st[$], rx_par[$];
  logic [7:0] mon_b;
  logic       mon_p;
  int         mon_st;
  always begin
    @(negedge clk);
    if (uart_tx === 1'b0 && rst === 1'b0) begin
      mon_st = cyc;
      mon_p  = 1'b0;
      repeat (C / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      if (NB == 11) begin
        repeat (C) @(negedge clk);
        mon_p = uart_tx;
      end
      repeat (C) @(negedge clk);
      rx_q.push_back(int'(mon_b));
      rx_st.push_back(mon_st);
      rx_par.push_back(int'(mon_p));
    end
  end

  task automatic flush_rx();
    rx_q.delete(); rx_st.delete(); rx_par.delete();
  endtask

  task automatic wait_idle(input int max, output int when);
    when = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!tx_busy && tx_empty) begin
        when = cyc;
        break;
      end
    end
    checks++;
    if (when < 0) begin
      failures++;
      $display("FAIL wait_idle: got timeout expected idle within %0d cycles", max);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int w, wc, fall;

  initial begin
    rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_empty", tx_empty, 1);
    chk("rst_full", tx_full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_overflow", tx_overflow, 0);
    rst = 1'b0;

    // Single byte 0xB2
    @(negedge clk);
    flush_rx();
    wc = cyc;
    tx_wr = 1'b1; tx_data = 8'hB2;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("lat_count1_empty", tx_empty, 0);
    chk("lat_count1_busy", tx_busy, 0);
    @(negedge clk);
    chk("lat_pop_busy", tx_busy, 1);
    chk("lat_pop_line", uart_tx, 0);
    chk("lat_pop_empty", tx_empty, 1);
    wait_idle(3 * FL, fall);
    chk("b2_frames", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      chk("b2_byte", rx_q[0], 8'hB2);
      chk("b2_start_lat", rx_st[0] - wc, 2);
      chk("b2_busy_len", fall - rx_st[0], NB * C);
    end

    // Overflow: ten consecutive writes into an empty FIFO
    do_reset();
    flush_rx();
    for (int i = 0; i < 10; i++) begin
      tx_wr = 1'b1; tx_data = 8'(i);
      @(negedge clk);
      if (i == 8) chk("ovf_full_after9", tx_full, 1);
      if (i == 8) chk("ovf_clear_after9", tx_overflow, 0);
    end
    tx_wr = 1'b0;
    chk("ovf_full", tx_full, 1);
    chk("ovf_sticky", tx_overflow, 1);
    wait_idle(12 * FL, fall);
    chk("ovf_frames", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      chk("ovf_byte", rx_q[i], i);
      if (i > 0) chk("ovf_gap", rx_st[i] - rx_st[i-1], NB * C);
    end

    // Write and pop on the same edge (last stop cycle)
    do_reset();
    flush_rx();
    tx_wr = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    tx_data = 8'hC5;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (FL - 1) @(negedge clk);
    tx_wr = 1'b1; tx_data = 8'h5A;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("simul_not_empty", tx_empty, 0);
    chk("simul_not_full", tx_full, 0);
    chk("simul_busy", tx_busy, 1);
    wait_idle(4 * FL, fall);
    chk("simul_frames", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("simul_b0", rx_q[0], 8'h3C);
      chk("simul_b1", rx_q[1], 8'hC5);
      chk("simul_b2", rx_q[2], 8'h5A);
      chk("simul_gap1", rx_st[1] - rx_st[0], NB * C);
      chk("simul_gap2", rx_st[2] - rx_st[1], NB * C);
    end

`ifdef UART_TX_PARITY_EN
    flush_rx();
    @(negedge clk);
    tx_wr = 1'b1; tx_data = 8'h07;
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle(3 * FL, fall);
    @(negedge clk);
    tx_wr = 1'b1; tx_data = 8'hAA;
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle(3 * FL, w);
    chk("par_frames", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("par_07_byte", rx_q[0], 8'h07);
      chk("par_07_bit", rx_par[0], 1);
      chk("par_07_len", fall - rx_st[0], 11 * C);
      chk("par_aa_byte", rx_q[1], 8'hAA);
      chk("par_aa_bit", rx_par[1], 0);
    end
`endif

    // Reset during DATA bit 3 of 0xAA with two bytes queued
    @(negedge clk);
    tx_wr = 1'b1; tx_data = 8'hAA;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (4 * C + C / 2 - 1) @(negedge clk);
    chk("midrst_busy_before", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_line", uart_tx, 1);
    chk("midrst_empty", tx_empty, 1);
    chk("midrst_busy", tx_busy, 0);
    repeat (12 * C) @(negedge clk);
    flush_rx();
    repeat (3 * FL) @(negedge clk);
    chk("midrst_no_frames", rx_q.size(), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      tx_wr   = ($urandom_range(0, 5) == 0);
      tx_data = 8'($urandom);
      rst     = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    tx_wr = 1'b0; rst = 1'b0;
    wait_idle(DEPTH * FL + 4 * FL, fall);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
